// File: rtl/psum_requant_drain_pkg.sv
// Shared constants, FSM state type and lane helpers for the
// partial-sum accumulate / requantize / drain block.
package psum_requant_drain_pkg;

  localparam int LANES  = 9;
  localparam int PSUM_W = 32;
  localparam int OFM_W  = 8;
  localparam int CNT_W  = 10;

  localparam logic signed [OFM_W-1:0] OFM_MAX =
    {1'b0, {(OFM_W-1){1'b1}}};
  localparam logic signed [OFM_W-1:0] OFM_MIN =
    {1'b1, {(OFM_W-1){1'b0}}};

  typedef enum logic {
    ST_ACC,
    ST_QUANT
  } state_t;

  function automatic logic signed [PSUM_W-1:0] psum_lane(
    input logic [LANES*PSUM_W-1:0] v,
    input int                      k
  );
    return v[k*PSUM_W +: PSUM_W];
  endfunction

  function automatic logic signed [OFM_W-1:0] ofm_lane(
    input logic [LANES*OFM_W-1:0] v,
    input int                     k
  );
    return v[k*OFM_W +: OFM_W];
  endfunction

endpackage

// File: rtl/psum_requant_drain_lane.sv
// requant_lane: acc+bias, round-half-up, arithmetic shift, ReLU, int8 saturate.
// Ports: acc/bias (PSUM_W signed), shift (5), relu -> y (OFM_W signed).
module requant_lane
  import psum_requant_drain_pkg::*;
(
  input  logic signed [PSUM_W-1:0] acc,
  input  logic signed [PSUM_W-1:0] bias,
  input  logic        [4:0]        shift,
  input  logic                     relu,
  output logic signed [OFM_W-1:0]  y
);

  // Two guard bits: the sum and the rounding term never wrap.
  localparam int TW = PSUM_W + 2;

  localparam logic signed [TW-1:0] HI =
    {{(TW-OFM_W){1'b0}}, OFM_MAX};
  localparam logic signed [TW-1:0] LO =
    {{(TW-OFM_W){1'b1}}, OFM_MIN};

  logic signed [TW-1:0] t;
  logic signed [TW-1:0] r;
  logic signed [TW-1:0] s;

  always_comb begin
    t = {{2{acc[PSUM_W-1]}}, acc}
      + {{2{bias[PSUM_W-1]}}, bias};
    r = t;
    if (shift != 5'd0)
      r = t + ({{(TW-1){1'b0}}, 1'b1} << (shift - 5'd1));
    s = r >>> shift;
    if (relu && s < 0)
      s = '0;
    if (s > HI)
      y = OFM_MAX;
    else if (s < LO)
      y = OFM_MIN;
    else
      y = s[OFM_W-1:0];
  end

endmodule

// File: rtl/psum_requant_drain.sv
// Accumulates groups of 9-lane psum vectors, requantizes to int8 and drains
// over valid/ready. Ports: psum_* in stream, acc_len/bias/shift/relu cfg, ofm_* out stream, busy.
module psum_requant_drain
  import psum_requant_drain_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [LANES*PSUM_W-1:0]   psum_i,
  input  logic [CNT_W-1:0]          acc_len,
  input  logic signed [PSUM_W-1:0]  bias_i,
  input  logic [4:0]                shift_i,
  input  logic                      relu_en,
  output logic                      ofm_valid,
  input  logic                      ofm_ready,
  output logic [LANES*OFM_W-1:0]    ofm_o,
  output logic                      busy
);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         len_q;
  logic [CNT_W-1:0]         len_eff;
  logic signed [PSUM_W-1:0] bias_q;
  logic [4:0]               shift_q;
  logic                     relu_q;
  logic signed [PSUM_W-1:0] acc [LANES];
  logic [LANES*OFM_W-1:0]   ofm_d;

  logic beat;
  logic first;
  logic last;
  logic load;

  assign psum_ready = (state == ST_ACC);
  assign beat  = psum_valid & psum_ready;
  assign first = (cnt == '0);

  // First beat compares against the live acc_len so a 1-pass
  // group closes on the very beat that opens it.
  assign len_eff = !first ? len_q :
                   (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign last = beat & (cnt == len_eff - 1'b1);
  assign load = (state == ST_QUANT) & (~ofm_valid | ofm_ready);
  assign busy = (cnt != '0) | (state == ST_QUANT) | ofm_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_ACC;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_ACC:   if (last) state_nx = ST_QUANT;
      ST_QUANT: if (load) state_nx = ST_ACC;
      default:  state_nx = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      len_q     <= CNT_W'(1);
      bias_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      ofm_o     <= '0;
      ofm_valid <= 1'b0;
      for (int k = 0; k < LANES; k++)
        acc[k] <= '0;
    end else begin
      if (beat) begin
        if (first) begin
          len_q   <= len_eff;
          bias_q  <= bias_i;
          shift_q <= shift_i;
          relu_q  <= relu_en;
        end
        for (int k = 0; k < LANES; k++)
          acc[k] <= first ? psum_lane(psum_i, k)
                          : acc[k] + psum_lane(psum_i, k);
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (load) begin
        ofm_o     <= ofm_d;
        ofm_valid <= 1'b1;
      end else if (ofm_ready) begin
        ofm_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_lane u_lane (
      .acc   (acc[g]),
      .bias  (bias_q),
      .shift (shift_q),
      .relu  (relu_q),
      .y     (ofm_d[g*OFM_W +: OFM_W])
    );
  end

endmodule

// File: tb/tb_psum_requant_drain.sv
// Scoreboard bench for psum_requant_drain: random and directed groups,
// reference model in plain integer arithmetic, decoupled output monitor.
module tb_psum_requant_drain;

  localparam int L  = 9;
  localparam int PW = 32;
  localparam int OW = 8;
  localparam int CW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 psum_valid = 1'b0;
  logic                 psum_ready;
  logic [L*PW-1:0]      psum_i = '0;
  logic [CW-1:0]        acc_len = '0;
  logic signed [PW-1:0] bias_i = '0;
  logic [4:0]           shift_i = '0;
  logic                 relu_en = 1'b0;
  logic                 ofm_valid;
  logic                 ofm_ready = 1'b0;
  logic [L*OW-1:0]      ofm_o;
  logic                 busy;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 2;
  logic [L*OW-1:0] exp_q[$];
  logic signed [PW-1:0] dval[L];

  psum_requant_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum_i     (psum_i),
    .acc_len    (acc_len),
    .bias_i     (bias_i),
    .shift_i    (shift_i),
    .relu_en    (relu_en),
    .ofm_valid  (ofm_valid),
    .ofm_ready  (ofm_ready),
    .ofm_o      (ofm_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic signed [PW-1:0] rand_lane();
    if ($urandom_range(0, 3) == 0)
      return $urandom;
    return int'($urandom_range(0, 40000)) - 20000;
  endfunction

  // Monitor: picks ofm_ready, checks hold stability and pops scoreboard.
  initial begin
    logic hold;
    logic [L*OW-1:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", 128'(ofm_valid), 128'(1));
          chk("hold_data", 128'(ofm_o), 128'(held));
        end
        case (ready_mode)
          0: ofm_ready = ($urandom_range(0, 2) != 0);
          1: ofm_ready = 1'b0;
          default: ofm_ready = 1'b1;
        endcase
        if (ofm_valid && ofm_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ofm_unexpected: got %h required none", ofm_o);
          end else begin
            chk("ofm", 128'(ofm_o), 128'(exp_q.pop_front()));
          end
        end
        hold = ofm_valid && !ofm_ready;
        held = ofm_o;
      end
    end
  end

  task automatic set_mode(input int m);
    @(posedge clk);
    ready_mode = m;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!psum_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!psum_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL psum_ready_timeout: got 0 required 1");
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || ofm_valid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0 || ofm_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending required 0",
               exp_q.size());
    end
  endtask

  // One group; config is driven only on the first beat, garbage after.
  task automatic run_group(input int alen, input logic signed [PW-1:0] b,
                           input logic [4:0] sh, input logic rl,
                           input bit use_dir, input int maxgap);
    logic signed [PW-1:0] am[L];
    logic signed [PW-1:0] ln;
    logic [L*OW-1:0] e;
    longint t;
    int n;
    n = (alen == 0) ? 1 : alen;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < L; k++) begin
        ln = use_dir ? dval[k] : rand_lane();
        psum_i[k*PW +: PW] = ln;
        am[k] = (i == 0) ? ln : am[k] + ln;
      end
      if (i == 0) begin
        acc_len = CW'(alen);
        bias_i  = b;
        shift_i = sh;
        relu_en = rl;
      end else begin
        acc_len = CW'($urandom);
        bias_i  = $urandom;
        shift_i = 5'($urandom);
        relu_en = 1'($urandom);
      end
      psum_valid = 1'b1;
      wait_ready();
      @(negedge clk);
      if (maxgap > 0 && i < n - 1) begin
        psum_valid = 1'b0;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
    end
    psum_valid = 1'b0;
    for (int k = 0; k < L; k++) begin
      t = longint'(am[k]) + longint'(b);
      if (sh != 0)
        t = t + (longint'(1) << (sh - 1));
      t = t >>> sh;
      if (rl && t < 0)
        t = 0;
      if (t > 127)
        t = 127;
      if (t < -128)
        t = -128;
      e[k*OW +: OW] = 8'(t);
    end
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ofm_valid", 128'(ofm_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ofm_o", 128'(ofm_o), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_psum_ready", 128'(psum_ready), 128'(1));
    chk("rst_busy_rel", 128'(busy), 128'(0));

    // single pass, latency two cycles after the beat
    for (int k = 0; k < L; k++) dval[k] = 100;
    run_group(1, 0, 0, 1'b0, 1'b1, 0);
    chk("lat_t1_valid", 128'(ofm_valid), 128'(0));
    chk("lat_t1_busy", 128'(busy), 128'(1));
    @(negedge clk);
    chk("lat_t2_valid", 128'(ofm_valid), 128'(1));
    drain();

    for (int k = 0; k < L; k++) dval[k] = 1000;
    run_group(3, -1000, 4, 1'b0, 1'b1, 0);
    drain();

    for (int k = 0; k < L; k++) dval[k] = 0;
    dval[0] = 5000;
    dval[1] = -5000;
    run_group(1, 0, 0, 1'b0, 1'b1, 0);
    run_group(1, 0, 0, 1'b1, 1'b1, 0);
    drain();

    for (int k = 0; k < L; k++) dval[k] = 32'h7FFF_FFFF;
    run_group(2, 0, 0, 1'b0, 1'b1, 0);
    run_group(0, 7, 1, 1'b0, 1'b1, 0);
    drain();

    // backpressure: second group stalls until first drains
    set_mode(1);
    run_group(2, 300, 3, 1'b0, 1'b0, 0);
    run_group(2, -50, 2, 1'b1, 1'b0, 0);
    chk("bp_psum_ready", 128'(psum_ready), 128'(0));
    chk("bp_busy", 128'(busy), 128'(1));
    @(negedge clk);
    chk("bp_stall", 128'(psum_ready), 128'(0));
    set_mode(2);
    chk("bp_stall2", 128'(psum_ready), 128'(0));
    @(negedge clk);
    chk("bp_reload_valid", 128'(ofm_valid), 128'(1));
    chk("bp_resume", 128'(psum_ready), 128'(1));
    drain();

    // reset after 1 of 4 beats
    for (int k = 0; k < L; k++) psum_i[k*PW +: PW] = 30000;
    acc_len = 4;
    bias_i = 0;
    shift_i = 0;
    relu_en = 1'b0;
    psum_valid = 1'b1;
    @(negedge clk);
    psum_valid = 1'b0;
    chk("mid_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 128'(ofm_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_busy", 128'(busy), 128'(0));
    chk("mid_rel_valid", 128'(ofm_valid), 128'(0));
    for (int k = 0; k < L; k++) dval[k] = k * 3 - 10;
    run_group(4, 5, 1, 1'b0, 1'b1, 0);
    drain();

    // random groups with random backpressure and beat gaps
    set_mode(0);
    for (int g = 0; g < 60; g++)
      run_group($urandom_range(0, 5), int'($urandom_range(0, 20000)) - 10000,
                5'($urandom_range(0, 12)), 1'($urandom), 1'b0, 2);
    drain();
    set_mode(2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
